// File: rtl/audio_pkg.sv
// audio_pkg: constants, sample type and a width helper shared by the audio output blocks.
package audio_pkg;

  localparam int unsigned SAMPLE_W   = 16;
  localparam int unsigned I2S_SLOT_W = 32;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // Counter width able to hold 0..n-1, never less than one bit
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// i2s_bclk_gen: divides clk down to BCLK and flags the clk edge on which BCLK falls.
module i2s_bclk_gen #(
  parameter int unsigned BCLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_bclk,
  output logic o_fall_c
);
  import audio_pkg::*;

  localparam int unsigned       DIV_W    = cnt_w(BCLK_DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(BCLK_DIV - 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic             r_bclk;
  logic             w_tc;

  assign w_tc = (r_div_cnt == DIV_LAST);

  // Half-period counter; BCLK toggles each time it wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
      r_bclk    <= 1'b0;
    end else if (w_tc) begin
      r_div_cnt <= '0;
      r_bclk    <= ~r_bclk;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  assign o_bclk   = r_bclk;
  // High on the cycle whose rising clk edge takes BCLK from 1 to 0
  assign o_fall_c = w_tc & r_bclk;

endmodule

// File: rtl/i2s_sample_tx.sv
// i2s_sample_tx: serialises a mono sample stream as Philips I2S, same sample in both slots,
// with a per-frame sample_req strobe.
// Optional: define I2S_TX_UNDERRUN_EN to add the sticky underrun output.
module i2s_sample_tx #(
  parameter int unsigned SAMPLE_W = audio_pkg::SAMPLE_W,
  parameter int unsigned SLOT_W   = audio_pkg::I2S_SLOT_W,
  parameter int unsigned BCLK_DIV = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid,
  input  logic [SAMPLE_W-1:0] sample_in,
  output logic                sample_req,
  output logic                bclk,
  output logic                lrclk,
`ifdef I2S_TX_UNDERRUN_EN
  output logic                sdata,
  output logic                underrun
`else
  output logic                sdata
`endif
);
  import audio_pkg::*;

  localparam int unsigned       FRAME_BITS  = 2 * SLOT_W;
  localparam int unsigned       CNT_W       = cnt_w(FRAME_BITS);
  localparam int unsigned       IDX_W       = cnt_w(SAMPLE_W);
  localparam logic [CNT_W-1:0]  BIT_LAST    = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0]  SLOT_FIRST  = CNT_W'(SLOT_W);
  localparam logic [CNT_W-1:0]  SAMPLE_LAST = CNT_W'(SAMPLE_W);

  logic                w_bclk;
  logic                w_fall;
  logic                w_boundary;
  logic                w_upper;
  logic                w_sdata_nxt;
  logic [CNT_W-1:0]    w_bit_nxt;
  logic [CNT_W-1:0]    w_k;
  logic [IDX_W-1:0]    w_idx;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic [SAMPLE_W-1:0] r_hold;
  logic [SAMPLE_W-1:0] r_frame;
  logic                r_lrclk;
  logic                r_sdata;
  logic                r_sample_req;

  i2s_bclk_gen #(
    .BCLK_DIV (BCLK_DIV)
  ) u_bclk_gen (
    .clk      (clk),
    .rst_n    (rst),
    .o_bclk   (w_bclk),
    .o_fall_c (w_fall)
  );

  // Frame boundary: the fall on which the bit counter wraps
  assign w_boundary = w_fall & (r_bit_cnt == BIT_LAST);

  // Next bit position and the serial bit it selects (one BCLK delay after each LRCLK edge)
  always_comb begin
    w_bit_nxt   = (r_bit_cnt == BIT_LAST) ? '0 : r_bit_cnt + CNT_W'(1);
    w_upper     = (w_bit_nxt >= SLOT_FIRST);
    w_k         = w_upper ? (w_bit_nxt - SLOT_FIRST) : w_bit_nxt;
    w_idx       = IDX_W'(SAMPLE_LAST - w_k);
    w_sdata_nxt = 1'b0;
    if ((w_k != '0) && (w_k <= SAMPLE_LAST)) begin
      w_sdata_nxt = r_frame[w_idx];
    end
  end

  // Holding register: the latest valid sample wins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold <= '0;
    end else if (valid) begin
      r_hold <= sample_in;
    end
  end

  // Bit position, frame capture and slot outputs advance only on BCLK falls
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bit_cnt <= '0;
      r_frame   <= '0;
      r_lrclk   <= 1'b0;
      r_sdata   <= 1'b0;
    end else if (w_fall) begin
      r_bit_cnt <= w_bit_nxt;
      r_lrclk   <= w_upper;
      r_sdata   <= w_sdata_nxt;
      if (w_boundary) begin
        r_frame <= r_hold;
      end
    end
  end

  // One-cycle request strobe per frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sample_req <= 1'b0;
    end else begin
      r_sample_req <= w_boundary;
    end
  end

`ifdef I2S_TX_UNDERRUN_EN
  logic r_armed;
  logic r_got_valid;
  logic r_underrun;

  // Sticky underrun: a boundary with no valid since the previous one; the first boundary only arms
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_armed     <= 1'b0;
      r_got_valid <= 1'b0;
      r_underrun  <= 1'b0;
    end else if (w_boundary) begin
      if (r_armed && !r_got_valid) begin
        r_underrun <= 1'b1;
      end
      r_armed     <= 1'b1;
      r_got_valid <= valid;
    end else if (valid) begin
      r_got_valid <= 1'b1;
    end
  end

  assign underrun = r_underrun;
`endif

  assign bclk       = w_bclk;
  assign lrclk      = r_lrclk;
  assign sdata      = r_sdata;
  assign sample_req = r_sample_req;

endmodule

// File: tb/tb_i2s_sample_tx.sv
// tb_i2s_sample_tx: cycle model for bclk/lrclk/sample_req plus an I2S receiver that checks each
// slot against a scoreboard of expected frame values.
module tb_i2s_sample_tx;

  localparam int SW        = 16;
  localparam int SLOT      = 32;
  localparam int DIV       = 2;
  localparam int FRAME_CYC = 2 * SLOT * 2 * DIV;

  logic          clk       = 1'b0;
  logic          rst       = 1'b0;
  logic          valid     = 1'b0;
  logic [SW-1:0] sample_in = '0;
  logic          sample_req;
  logic          bclk;
  logic          lrclk;
  logic          sdata;
`ifdef I2S_TX_UNDERRUN_EN
  logic          underrun;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int req_cnt = 0;

  logic [SW-1:0] model_hold = '0;
  logic [SW-1:0] sb [$];

  logic          rx_prev_bclk = 1'b0;
  logic          rx_prev_lr   = 1'b1;
  int            rx_pos       = 0;
  logic [SW-1:0] rx_word      = '0;
  logic          rx_pad_ok    = 1'b1;
  logic [SW-1:0] rx_last [2];
  logic [SW-1:0] rx_exp;

  logic exp_bclk;
  logic exp_lr;
  logic exp_req;

  always #5 clk = ~clk;

  i2s_sample_tx #(
    .SAMPLE_W (SW),
    .SLOT_W   (SLOT),
    .BCLK_DIV (DIV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .valid      (valid),
    .sample_in  (sample_in),
    .sample_req (sample_req),
    .bclk       (bclk),
    .lrclk      (lrclk),
`ifdef I2S_TX_UNDERRUN_EN
    .sdata      (sdata),
    .underrun   (underrun)
`else
    .sdata      (sdata)
`endif
  );

  // Reference model: edge counter, holding register, frame values pushed at each boundary
  initial forever begin
    @(posedge clk);
    if (!rst) begin
      cyc        = 0;
      model_hold = '0;
      sb.delete();
    end else begin
      cyc = cyc + 1;
      if (cyc == 1 || (cyc % FRAME_CYC) == 0) begin
        sb.push_back(model_hold);
        sb.push_back(model_hold);
      end
      if (valid) model_hold = sample_in;
    end
  end

  // Timing checks and I2S receiver, sampled on the falling clk edge
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      rx_prev_bclk = 1'b0;
      rx_prev_lr   = 1'b1;
      rx_pos       = 0;
      rx_word      = '0;
      rx_pad_ok    = 1'b1;
    end else begin
      exp_bclk = ((cyc / DIV) % 2) == 1;
      exp_lr   = (((cyc / (2 * DIV)) % (2 * SLOT)) >= SLOT);
      exp_req  = (cyc != 0) && ((cyc % FRAME_CYC) == 0);
      n_tests = n_tests + 3;
      if (bclk !== exp_bclk) begin
        n_fail++;
        $display("FAIL bclk cyc=%0d: got %b want %b", cyc, bclk, exp_bclk);
      end
      if (lrclk !== exp_lr) begin
        n_fail++;
        $display("FAIL lrclk cyc=%0d: got %b want %b", cyc, lrclk, exp_lr);
      end
      if (sample_req !== exp_req) begin
        n_fail++;
        $display("FAIL sample_req cyc=%0d: got %b want %b", cyc, sample_req, exp_req);
      end
      if (sample_req === 1'b1) req_cnt++;

      if (bclk === 1'b1 && rx_prev_bclk === 1'b0) begin
        if (lrclk !== rx_prev_lr) begin
          rx_pos    = 0;
          rx_word   = '0;
          rx_pad_ok = (sdata === 1'b0);
        end else begin
          rx_pos = rx_pos + 1;
          if (rx_pos <= SW) rx_word = {rx_word[SW-2:0], sdata};
          else if (sdata !== 1'b0) rx_pad_ok = 1'b0;
        end
        rx_prev_lr = lrclk;
        if (rx_pos == SLOT - 1) begin
          n_tests++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL slot_sb_empty cyc=%0d: got word %h, want a queued frame", cyc, rx_word);
          end else begin
            rx_exp = sb.pop_front();
            if (rx_word !== rx_exp || rx_pad_ok !== 1'b1) begin
              n_fail++;
              $display("FAIL slot_word lr=%b cyc=%0d: got %h pad_ok=%b want %h pad_ok=1",
                       lrclk, cyc, rx_word, rx_pad_ok, rx_exp);
            end
          end
          rx_last[lrclk] = rx_word;
        end
      end
      rx_prev_bclk = bclk;
    end
  end

  // Advance to just after clk edge n (counted from reset release)
  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one sample so that it is captured on edge e
  task automatic write_at(input int e, input logic [SW-1:0] v);
    goto(e - 1);
    valid     = 1'b1;
    sample_in = v;
    goto(e);
    valid     = 1'b0;
  endtask

  task automatic check_slots(input string name, input logic [SW-1:0] want);
    n_tests = n_tests + 2;
    if (rx_last[0] !== want) begin
      n_fail++;
      $display("FAIL %s_left: got %h want %h", name, rx_last[0], want);
    end
    if (rx_last[1] !== want) begin
      n_fail++;
      $display("FAIL %s_right: got %h want %h", name, rx_last[1], want);
    end
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests = n_tests + 4;
    if (bclk !== 1'b0)       begin n_fail++; $display("FAIL reset_bclk: got %b want 0", bclk); end
    if (lrclk !== 1'b0)      begin n_fail++; $display("FAIL reset_lrclk: got %b want 0", lrclk); end
    if (sdata !== 1'b0)      begin n_fail++; $display("FAIL reset_sdata: got %b want 0", sdata); end
    if (sample_req !== 1'b0) begin n_fail++; $display("FAIL reset_sample_req: got %b want 0", sample_req); end
`ifdef I2S_TX_UNDERRUN_EN
    n_tests++;
    if (underrun !== 1'b0)   begin n_fail++; $display("FAIL reset_underrun: got %b want 0", underrun); end
`endif
    rst = 1'b1;
  endtask

  task automatic test_idle();
    int lr_hi;
    lr_hi   = 0;
    req_cnt = 0;
    goto(FRAME_CYC);
    for (int i = 0; i < FRAME_CYC; i++) begin
      @(posedge clk);
      #1;
      if (lrclk === 1'b1) lr_hi++;
    end
    goto(600);
    n_tests = n_tests + 2;
    if (lr_hi != SLOT * 2 * DIV) begin
      n_fail++;
      $display("FAIL idle_lrclk_high_cycles: got %0d want %0d", lr_hi, SLOT * 2 * DIV);
    end
    if (req_cnt != 2) begin
      n_fail++;
      $display("FAIL idle_sample_req_count: got %0d want 2", req_cnt);
    end
  endtask

  task automatic test_pattern();
    write_at(700, 16'hA5C3);
    goto(4 * FRAME_CYC + 4);
    check_slots("pattern", 16'hA5C3);
  endtask

  // Write lands on the boundary edge itself: old value this frame, new value the next
  task automatic test_same_cycle();
    write_at(5 * FRAME_CYC, 16'h8000);
    n_tests++;
    if (sample_req !== 1'b1) begin
      n_fail++;
      $display("FAIL same_cycle_req: got %b want 1", sample_req);
    end
    goto(6 * FRAME_CYC + 4);
    check_slots("same_cycle_old", 16'hA5C3);
    goto(7 * FRAME_CYC + 4);
    check_slots("same_cycle_new", 16'h8000);
  endtask

  task automatic test_back_to_back();
    write_at(1900, 16'h0001);
    write_at(1950, 16'h7FFF);
    goto(9 * FRAME_CYC + 4);
    check_slots("back_to_back", 16'h7FFF);
  endtask

  // Right slot, bit 7 of frame 9 (value 7FFF): lrclk=1, sdata=bit 9=1, bclk high
  task automatic test_reset_mid();
    goto(2462);
    n_tests = n_tests + 3;
    if (lrclk !== 1'b1) begin n_fail++; $display("FAIL mid_pre_lrclk: got %b want 1", lrclk); end
    if (sdata !== 1'b1) begin n_fail++; $display("FAIL mid_pre_sdata: got %b want 1", sdata); end
    if (bclk !== 1'b1)  begin n_fail++; $display("FAIL mid_pre_bclk: got %b want 1", bclk); end
    rst = 1'b0;
    #1;
    n_tests = n_tests + 4;
    if (bclk !== 1'b0)       begin n_fail++; $display("FAIL mid_bclk: got %b want 0", bclk); end
    if (lrclk !== 1'b0)      begin n_fail++; $display("FAIL mid_lrclk: got %b want 0", lrclk); end
    if (sdata !== 1'b0)      begin n_fail++; $display("FAIL mid_sdata: got %b want 0", sdata); end
    if (sample_req !== 1'b0) begin n_fail++; $display("FAIL mid_sample_req: got %b want 0", sample_req); end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    test_idle();
  endtask

`ifdef I2S_TX_UNDERRUN_EN
  task automatic test_underrun();
    test_reset();
    write_at(100, 16'h1234);
    write_at(300, 16'h4321);
    goto(700);
    n_tests++;
    if (underrun !== 1'b0) begin n_fail++; $display("FAIL underrun_fed: got %b want 0", underrun); end
    goto(3 * FRAME_CYC + 1);
    n_tests++;
    if (underrun !== 1'b1) begin n_fail++; $display("FAIL underrun_rise: got %b want 1", underrun); end
    write_at(800, 16'h5555);
    goto(1100);
    n_tests++;
    if (underrun !== 1'b1) begin n_fail++; $display("FAIL underrun_sticky: got %b want 1", underrun); end
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog: still running at %0t, want finish", $time);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_idle();
    test_pattern();
    test_same_cycle();
    test_back_to_back();
    test_reset_mid();
`ifdef I2S_TX_UNDERRUN_EN
    test_underrun();
`endif
    test_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
